// File: rtl/wb_scratch_pkg.sv
// Shared definitions for the Wishbone scratchpad RAM.
//   - wb_state_t : controller state (INIT zero-fills the RAM, READY serves the bus)
//   - WB_DW      : bus data width
//   - WB_SELW    : number of byte lanes
//   - latency_ok : legal range of the response latency parameter
package wb_scratch_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } wb_state_t;

  localparam int WB_DW   = 32;
  localparam int WB_SELW = 4;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  function automatic bit latency_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/wb_ack_pipe.sv
// Fixed-latency completion pipeline for the scratchpad.
// Carries valid/err flags through LATENCY stages and read data alongside them.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cyc           bus cycle; low flushes every in-flight response
//   in_vld        request accepted this cycle
//   in_err        accepted request is an error completion
//   in_rd         accepted request is a read
//   in_data       RAM word addressed by the accepted request
//   ack, err      completion strobes, LATENCY cycles after accept
//   data          read data, updated only by read completions
module wb_ack_pipe
  import wb_scratch_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cyc,
  input  logic             in_vld,
  input  logic             in_err,
  input  logic             in_rd,
  input  logic [WB_DW-1:0] in_data,
  output logic             ack,
  output logic             err,
  output logic [WB_DW-1:0] data
);

  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] err_p;
  logic               ld_in;
  logic               ld_fin;
  logic [WB_DW-1:0]   fin_src;
  logic [WB_DW-1:0]   data_q;

  // Only successful reads move data; everything else leaves it untouched.
  assign ld_in = in_vld && in_rd && !in_err;

  // Stage 0..LATENCY-1: completion flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      err_p <= '0;
    end else begin
      err_p[0] <= in_err;
      for (int s = 1; s < LATENCY; s++) err_p[s] <= err_p[s-1];
      if (!cyc) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= in_vld;
        for (int s = 1; s < LATENCY; s++) vld_p[s] <= vld_p[s-1];
      end
    end
  end

  if (LATENCY == 1) begin : g_direct
    assign ld_fin  = ld_in;
    assign fin_src = in_data;
  end else begin : g_mid
    logic [LATENCY-2:0]            rd_ok_p;
    logic [LATENCY-2:0][WB_DW-1:0] data_p;

    // Stage 0..LATENCY-2: read-data qualifier (meaningful only with vld_p)
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ok_p <= '0;
      end else begin
        rd_ok_p[0] <= ld_in;
        for (int s = 1; s < LATENCY - 1; s++) rd_ok_p[s] <= rd_ok_p[s-1];
      end
    end

    // Stage 0..LATENCY-2: read data
    always_ff @(posedge clk) begin
      if (ld_in) data_p[0] <= in_data;
      for (int s = 1; s < LATENCY - 1; s++) begin
        if (rd_ok_p[s-1]) data_p[s] <= data_p[s-1];
      end
    end

    assign ld_fin  = vld_p[LATENCY-2] && rd_ok_p[LATENCY-2];
    assign fin_src = data_p[LATENCY-2];
  end

  // Output stage: data holds unless a read completes into it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (ld_fin && cyc) begin
      data_q <= fin_src;
    end
  end

  // A response presented while cyc is low would belong to an abandoned
  // cycle, so it is masked the same cycle the flush is requested.
  assign ack  = vld_p[LATENCY-1] && !err_p[LATENCY-1] && cyc;
  assign err  = vld_p[LATENCY-1] &&  err_p[LATENCY-1] && cyc;
  assign data = data_q;

endmodule

// File: rtl/wb_scratchpad.sv
// Pipelined Wishbone responder backed by a zero-initialised block RAM.
// After reset the RAM is cleared one word per cycle (bus stalled), then one
// request per cycle is accepted and completed LATENCY cycles later.
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_wb_cyc, i_wb_stb       bus cycle / request strobe
//   i_wb_we                  1 = write, 0 = read
//   i_wb_addr [AW]           word address
//   i_wb_data [32]           write data
//   i_wb_sel  [4]            byte enables, bit 3 = bits 31:24
//   o_wb_stall               request not accepted this cycle
//   o_wb_ack, o_wb_err       completion strobes
//   o_wb_data [32]           read data, valid with o_wb_ack
module wb_scratchpad
  import wb_scratch_pkg::*;
#(
  parameter int AW      = 30,
  parameter int LGMEMSZ = 10,
  parameter int LATENCY = 2,
  parameter int OPT_ERR = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wb_cyc,
  input  logic               i_wb_stb,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [WB_DW-1:0]   i_wb_data,
  input  logic [WB_SELW-1:0] i_wb_sel,
  output logic               o_wb_stall,
  output logic               o_wb_ack,
  output logic [WB_DW-1:0]   o_wb_data,
  output logic               o_wb_err
);

  localparam int NWORDS = 1 << LGMEMSZ;
  // One extra counter bit keeps the terminal compare away from wrap-around.
  localparam logic [LGMEMSZ:0] LAST_WORD = (LGMEMSZ + 1)'(NWORDS - 1);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("wb_scratchpad: LATENCY must be within 1..4");
  end

  wb_state_t          state_q, state_d;
  logic [LGMEMSZ:0]   cnt_q, cnt_d;
  logic               init_we;
  logic               stall;

  logic               accept;
  logic               oor;
  logic               wr_en;
  logic [LGMEMSZ-1:0] addr_idx;
  logic [WB_DW-1:0]   ram_rd;
  logic [WB_DW-1:0]   wr_word;
  logic [WB_DW-1:0]   mem [NWORDS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    stall   = 1'b1;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_d   = cnt_q + (LGMEMSZ + 1)'(1);
        if (cnt_q == LAST_WORD) state_d = ST_READY;
      end
      ST_READY: begin
        stall = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign o_wb_stall = stall;
  assign accept     = i_wb_cyc && i_wb_stb && !stall;
  assign oor        = (OPT_ERR != 0) && (i_wb_addr[AW-1:LGMEMSZ] != '0);
  assign addr_idx   = i_wb_addr[LGMEMSZ-1:0];
  assign wr_en      = accept && i_wb_we && !oor;
  assign ram_rd     = mem[addr_idx];

  // Byte-lane merge: unselected lanes keep their stored value.
  always_comb begin
    wr_word = ram_rd;
    for (int b = 0; b < WB_SELW; b++) begin
      if (i_wb_sel[b]) wr_word[8*b +: 8] = i_wb_data[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (init_we) begin
      mem[cnt_q[LGMEMSZ-1:0]] <= '0;
    end else if (wr_en) begin
      mem[addr_idx] <= wr_word;
    end
  end

  // The RAM word is captured at the accept edge inside the pipe, which
  // makes a write followed next cycle by a read return the new data.
  wb_ack_pipe #(
    .LATENCY (LATENCY)
  ) u_ack_pipe (
    .clk     (i_clk),
    .rst     (i_reset),
    .cyc     (i_wb_cyc),
    .in_vld  (accept),
    .in_err  (oor),
    .in_rd   (!i_wb_we),
    .in_data (ram_rd),
    .ack     (o_wb_ack),
    .err     (o_wb_err),
    .data    (o_wb_data)
  );

endmodule

// File: tb/tb_wb_scratchpad.sv
module tb_wb_scratchpad;

  localparam int LG  = 4;
  localparam int NW  = 1 << LG;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        stall, ack, err;
  logic [31:0] rdat;

  wb_scratchpad #(.AW(30), .LGMEMSZ(LG), .LATENCY(LAT), .OPT_ERR(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
    .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(rdat), .o_wb_err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          is_err;
    bit          rd;
    logic [31:0] data;
  } resp_t;

  logic [31:0] ref_mem [NW];
  resp_t       pend[$];
  int          now = 0;
  int          ready_at = 0;
  logic [31:0] last_rdata = '0;
  bit          rdata_known = 1'b0;

  logic        s_stall, s_ack, s_err, s_acc;
  logic [31:0] s_data;

  // One bus cycle: drive, sample mid-cycle, compare with the model, advance.
  task automatic step(input bit c, input bit s, input bit w, input int a,
                      input logic [31:0] d, input logic [3:0] m);
    bit e_ack, e_err, head_due;
    cyc = c; stb = s; we = w; addr = 30'(a); wdat = d; sel = m;
    @(negedge clk);
    s_stall = stall; s_ack = ack; s_err = err; s_data = rdat;
    check("stall", 32'(s_stall), 32'(now < ready_at));
    head_due = (pend.size() > 0) && (pend[0].due == now);
    e_ack = head_due && c && !pend[0].is_err;
    e_err = head_due && c &&  pend[0].is_err;
    if (head_due && !c && pend[0].rd && !pend[0].is_err) rdata_known = 1'b0;
    check("ack", 32'(s_ack), 32'(e_ack));
    check("err", 32'(s_err), 32'(e_err));
    check("ack_err_excl", 32'(s_ack & s_err), 32'd0);
    if (e_ack && pend[0].rd) begin
      check("rd_data", s_data, pend[0].data);
      last_rdata  = pend[0].data;
      rdata_known = 1'b1;
    end else if (rdata_known) begin
      check("data_hold", s_data, last_rdata);
    end
    if (head_due) void'(pend.pop_front());
    if (!c) pend.delete();
    s_acc = c && s && !s_stall;
    if (s_acc) begin
      resp_t r;
      r.due = now + LAT; r.is_err = (a >= NW); r.rd = !w; r.data = ref_mem[a % NW];
      pend.push_back(r);
      if (w && a < NW)
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk); #1;
    now++;
  endtask

  task automatic do_reset();
    cyc = 0; stb = 0; we = 0;
    rst = 1'b1;
    #1;
    check("rst_async_data", rdat, 32'd0);
    check("rst_async_stall", 32'(stall), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd1);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_data", rdat, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    pend.delete();
    ready_at = now + NW;
    for (int i = 0; i < NW; i++) ref_mem[i] = '0;
    last_rdata = '0;
    rdata_known = 1'b1;
  endtask

  task automatic count_init(input string name);
    int n = 0;
    bit done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      step(0, 0, 0, 0, 0, 0);
      if (s_stall) n++; else done = 1;
    end
    check(name, 32'(n), 32'(NW));
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    bit          w;
    int          a;
    logic [31:0] d;
    logic [3:0]  m;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int lat = -1;
    step(1, 1, v.w, v.a, v.d, v.m);
    check("vec_accept", 32'(s_acc), 32'd1);
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      step(1, 0, 0, 0, 0, 0);
      if (s_ack || s_err) begin
        lat = k;
        check("vec_ack", 32'(s_ack), 32'(!v.exp_err));
        check("vec_err", 32'(s_err), 32'(v.exp_err));
        if (!v.w && !v.exp_err) check("vec_data", s_data, v.exp_data);
      end
    end
    check("vec_latency", 32'(lat), 32'(LAT));
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 7,  32'hAABBCCDD, 4'hF,    0, 32'h0};
    vecs[1]  = '{1, 7,  32'h11223344, 4'b0101, 0, 32'h0};
    vecs[2]  = '{0, 7,  32'h0,        4'hF,    0, 32'hAA22CC44};
    vecs[3]  = '{0, 5,  32'h0,        4'hF,    0, 32'h00000000};
    vecs[4]  = '{1, 7,  32'hFFFFFFFF, 4'h0,    0, 32'h0};
    vecs[5]  = '{0, 7,  32'h0,        4'h3,    0, 32'hAA22CC44};
    vecs[6]  = '{1, 20, 32'h12345678, 4'hF,    1, 32'h0};
    vecs[7]  = '{0, 4,  32'h0,        4'hF,    0, 32'h00000000};
    vecs[8]  = '{0, 16, 32'h0,        4'hF,    1, 32'h0};
    vecs[9]  = '{1, 15, 32'hCAFEF00D, 4'b1001, 0, 32'h0};
    vecs[10] = '{0, 15, 32'h0,        4'hF,    0, 32'hCA00000D};
    vecs[11] = '{0, 31, 32'h0,        4'hF,    1, 32'h0};

    @(posedge clk); #1;
    do_reset();
    count_init("init_stall_cycles");

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // write then immediate read of the same word
    begin
      logic [31:0] d_prev;
      step(1, 1, 1, 3, 32'hDEADBEEF, 4'hF);
      step(1, 1, 0, 3, 32'h0, 4'h5);
      d_prev = s_data;
      step(1, 0, 0, 0, 0, 0);
      check("wr_ack", 32'(s_ack), 32'd1);
      check("wr_ack_data_unchanged", s_data, d_prev);
      step(1, 0, 0, 0, 0, 0);
      check("raw_ack", 32'(s_ack), 32'd1);
      check("raw_data", s_data, 32'hDEADBEEF);
    end

    // error completion followed by a normal one
    run_vec('{1, 2, 32'h0BAD0002, 4'hF, 0, 32'h0});
    step(1, 1, 0, 16, 0, 4'hF);
    step(1, 1, 0, 2, 0, 4'hF);
    step(1, 0, 0, 0, 0, 0);
    check("oor_err", 32'(s_err), 32'd1);
    check("oor_no_ack", 32'(s_ack), 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("next_ack", 32'(s_ack), 32'd1);
    check("next_no_err", 32'(s_err), 32'd0);
    check("next_data", s_data, 32'h0BAD0002);

    // abort with three reads in flight
    begin
      int acks = 0;
      step(1, 1, 0, 7, 0, 4'hF); acks += int'(s_ack);
      step(1, 1, 0, 5, 0, 4'hF); acks += int'(s_ack);
      step(1, 1, 0, 3, 0, 4'hF); acks += int'(s_ack);
      step(0, 0, 0, 0, 0, 0);    acks += int'(s_ack | s_err);
      for (int k = 0; k < 3; k++) begin
        step(1, 0, 0, 0, 0, 0); acks += int'(s_ack | s_err);
      end
      check("abort_ack_count", 32'(acks), 32'd1);
      run_vec('{0, 7, 32'h0, 4'hF, 0, 32'hAA22CC44});
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
           int'($urandom_range(0, 19)), $urandom, 4'($urandom));
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0, 0);

    // reset during zero-fill restarts it
    run_vec('{1, 9, 32'h99999999, 4'hF, 0, 32'h0});
    run_vec('{0, 9, 32'h0, 4'hF, 0, 32'h99999999});
    do_reset();
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, 0);
    do_reset();
    count_init("reinit_stall_cycles");
    run_vec('{0, 9, 32'h0, 4'hF, 0, 32'h00000000});
    run_vec('{0, 3, 32'h0, 4'hF, 0, 32'h00000000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
